// File: rtl/tlb_cam_ctrl.sv
// Command-side controller for the block-RAM TLB CAM: sequences insert/invalidate/flush
// against the CAM write port, tracks entry validity and serves registered tag->PPN lookups.
module tlb_cam_ctrl #(
   parameter int TAG_WIDTH  = 16,
   parameter int ADDR_WIDTH = 5,
   parameter int PPN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [TAG_WIDTH-1:0]  cmd_tag,
   input  logic [PPN_WIDTH-1:0]  cmd_ppn,
   input  logic [ADDR_WIDTH-1:0] cmd_index,
   input  logic [TAG_WIDTH-1:0]  lookup_tag,
   output logic                  lookup_hit,
   output logic [PPN_WIDTH-1:0]  lookup_ppn,
   output logic                  lookup_stall,
   output logic [ADDR_WIDTH-1:0] cam_write_addr,
   output logic [TAG_WIDTH-1:0]  cam_write_data,
   output logic                  cam_write_enable,
   output logic                  cam_write_delete,
   input  logic                  cam_write_busy,
   output logic                  cam_rst_clr,
   output logic [TAG_WIDTH-1:0]  cam_compare_data,
   input  logic                  cam_match,
   input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

   localparam int ENTRIES = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      PROBE_KEY,
      PROBE_SAMPLE,
      ISSUE_WR,
      ISSUE_DEL,
      FLUSH,
      WAIT
   } state_t;

   state_t state, state_next;

   logic [ENTRIES-1:0]    valid;
   logic [ADDR_WIDTH-1:0] rr_ptr;
   logic [TAG_WIDTH-1:0]  lat_tag;
   logic [PPN_WIDTH-1:0]  lat_ppn;
   logic                  wait_first;

   logic [PPN_WIDTH-1:0]  ppn_ram [ENTRIES];
   logic [PPN_WIDTH-1:0]  ppn_rd;

   logic                  accept;
   logic                  probe_hit;
   logic                  hit_next;
   logic                  free_found;
   logic [ADDR_WIDTH-1:0] free_idx;
   logic [ADDR_WIDTH-1:0] target;
   logic                  use_rr;
   logic                  issuing;

   assign cmd_ready        = (state == IDLE) && !cam_write_busy && !rst;
   assign accept           = cmd_valid && cmd_ready;
   assign lookup_stall     = (state == PROBE_KEY) || (state == PROBE_SAMPLE) || (state == ISSUE_WR);
   assign cam_compare_data = ((state == PROBE_KEY) || (state == PROBE_SAMPLE)) ? lat_tag : lookup_tag;

   // Strobes are combinational from state so a reset drops them in the same cycle.
   assign cam_write_enable = (state == ISSUE_WR)  && !cam_write_busy;
   assign cam_write_delete = (state == ISSUE_DEL) && !cam_write_busy;
   assign cam_rst_clr      = (state == FLUSH)     && !cam_write_busy;
   assign issuing          = cam_write_enable || cam_write_delete || cam_rst_clr;

   assign probe_hit = cam_match && valid[cam_match_addr];
   assign hit_next  = probe_hit && !lookup_stall;
   assign lookup_ppn = lookup_hit ? ppn_rd : '0;

   // Lowest free entry: scan from the top so the smallest index wins.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_found = 1'b1;
            free_idx   = ADDR_WIDTH'(i);
         end
      end
   end

   always_comb begin
      use_rr = 1'b0;
      target = rr_ptr;
      if (probe_hit) begin
         target = cam_match_addr;
      end else if (free_found) begin
         target = free_idx;
      end else begin
         use_rr = 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               case (cmd_op)
                  2'b00:   state_next = PROBE_KEY;
                  2'b01:   state_next = ISSUE_DEL;
                  2'b10:   state_next = FLUSH;
                  default: state_next = IDLE;
               endcase
            end
         end
         PROBE_KEY:    state_next = PROBE_SAMPLE;
         PROBE_SAMPLE: state_next = ISSUE_WR;
         ISSUE_WR:     if (!cam_write_busy) state_next = WAIT;
         ISSUE_DEL:    if (!cam_write_busy) state_next = WAIT;
         FLUSH:        if (!cam_write_busy) state_next = WAIT;
         WAIT:         if (!wait_first && !cam_write_busy) state_next = IDLE;
         default:      state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         valid          <= '0;
         rr_ptr         <= '0;
         lat_tag        <= '0;
         lat_ppn        <= '0;
         wait_first     <= 1'b0;
         lookup_hit     <= 1'b0;
         cam_write_addr <= '0;
         cam_write_data <= '0;
      end else begin
         state      <= state_next;
         lookup_hit <= hit_next;
         // The CAM may raise busy only one cycle after a strobe, so WAIT always lingers once.
         wait_first <= issuing;
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_tag <= cmd_tag;
                  lat_ppn <= cmd_ppn;
                  if (cmd_op == 2'b01) begin
                     cam_write_addr <= cmd_index;
                  end
               end
            end
            PROBE_SAMPLE: begin
               cam_write_addr <= target;
               cam_write_data <= lat_tag;
               if (use_rr) begin
                  rr_ptr <= rr_ptr + 1'b1;
               end
            end
            ISSUE_WR:  if (cam_write_enable) valid[cam_write_addr] <= 1'b1;
            ISSUE_DEL: if (cam_write_delete) valid[cam_write_addr] <= 1'b0;
            FLUSH: begin
               if (cam_rst_clr) begin
                  valid  <= '0;
                  rr_ptr <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // PPN storage kept reset-free so it maps onto block RAM with a registered read.
   always_ff @(posedge clk) begin
      if (cam_write_enable) begin
         ppn_ram[cam_write_addr] <= lat_ppn;
      end
      ppn_rd <= ppn_ram[cam_match_addr];
   end

endmodule

// File: tb/tb_tlb_cam_ctrl.sv
// Randomised scoreboard bench for tlb_cam_ctrl with a behavioural CAM and an array-based TLB model.
module tb_tlb_cam_ctrl;
   localparam int TW = 16;
   localparam int AW = 5;
   localparam int PW = 16;
   localparam int N  = 32;
   localparam int K_WR  = 4;
   localparam int K_DEL = 2;
   localparam int K_CLR = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [TW-1:0] cmd_tag = '0;
   logic [PW-1:0] cmd_ppn = '0;
   logic [AW-1:0] cmd_index = '0;
   logic [TW-1:0] lookup_tag = '0;
   logic          lookup_hit;
   logic [PW-1:0] lookup_ppn;
   logic          lookup_stall;
   logic [AW-1:0] cam_write_addr;
   logic [TW-1:0] cam_write_data;
   logic          cam_write_enable;
   logic          cam_write_delete;
   logic          cam_write_busy;
   logic          cam_rst_clr;
   logic [TW-1:0] cam_compare_data;
   logic          cam_match = 1'b0;
   logic [AW-1:0] cam_match_addr = '0;

   always #5 clk = ~clk;

   tlb_cam_ctrl #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .PPN_WIDTH(PW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_tag(cmd_tag), .cmd_ppn(cmd_ppn), .cmd_index(cmd_index),
      .lookup_tag(lookup_tag), .lookup_hit(lookup_hit), .lookup_ppn(lookup_ppn),
      .lookup_stall(lookup_stall),
      .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
      .cam_write_enable(cam_write_enable), .cam_write_delete(cam_write_delete),
      .cam_write_busy(cam_write_busy), .cam_rst_clr(cam_rst_clr),
      .cam_compare_data(cam_compare_data), .cam_match(cam_match),
      .cam_match_addr(cam_match_addr)
   );

   int     vectors = 0;
   int     errors  = 0;
   longint cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural CAM: registered match, busy at power-up and after each operation,
   // write address/data sampled only on the last busy cycle.
   logic [TW-1:0] cam_tag [N];
   logic [N-1:0]  cam_v = '0;
   int            busy_cnt = 25;
   int            pend = 0;
   assign cam_write_busy = (busy_cnt != 0);

   function automatic logic [AW:0] cam_search(input logic [TW-1:0] key);
      logic [AW:0] res;
      res = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (cam_v[i] && cam_tag[i] == key) res = {1'b1, AW'(i)};
      end
      return res;
   endfunction

   always @(posedge clk) begin
      {cam_match, cam_match_addr} <= cam_search(cam_compare_data);
      if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) begin
            case (pend)
               K_WR: begin
                  cam_tag[cam_write_addr] <= cam_write_data;
                  cam_v[cam_write_addr]   <= 1'b1;
               end
               K_DEL:   cam_v[cam_write_addr] <= 1'b0;
               K_CLR:   cam_v <= '0;
               default: ;
            endcase
         end
      end else if (cam_write_enable) begin
         busy_cnt <= 3; pend <= K_WR;
      end else if (cam_write_delete) begin
         busy_cnt <= 3; pend <= K_DEL;
      end else if (cam_rst_clr) begin
         busy_cnt <= 6; pend <= K_CLR;
      end
   end

   // Reference TLB model
   logic [TW-1:0] m_tag [N];
   logic [PW-1:0] m_ppn [N];
   bit            m_val [N];
   int            m_rr = 0;

   typedef struct {int kind; logic [AW-1:0] addr; logic [TW-1:0] data;} wexp_t;
   typedef struct {longint due; logic hit; logic [PW-1:0] ppn;} lexp_t;
   wexp_t wr_q[$];
   lexp_t lk_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_val[i] = 1'b0;
      m_rr = 0;
   endtask

   task automatic model_apply(input logic [1:0] op, input logic [TW-1:0] tag,
                              input logic [PW-1:0] ppn, input logic [AW-1:0] idx);
      wexp_t e;
      int    slot;
      case (op)
         2'b00: begin
            slot = -1;
            for (int i = 0; i < N; i++) if (m_val[i] && m_tag[i] == tag) slot = i;
            if (slot < 0) begin
               for (int i = 0; i < N; i++) if (!m_val[i]) begin slot = i; break; end
            end
            if (slot < 0) begin
               slot = m_rr;
               m_rr = (m_rr + 1) % N;
            end
            m_val[slot] = 1'b1; m_tag[slot] = tag; m_ppn[slot] = ppn;
            e.kind = K_WR; e.addr = AW'(slot); e.data = tag;
            wr_q.push_back(e);
         end
         2'b01: begin
            m_val[idx] = 1'b0;
            e.kind = K_DEL; e.addr = idx; e.data = '0;
            wr_q.push_back(e);
         end
         2'b10: begin
            model_reset();
            e.kind = K_CLR; e.addr = '0; e.data = '0;
            wr_q.push_back(e);
         end
         default: ;
      endcase
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!cmd_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("ready_timeout", 32'(n >= 400), 32'(0));
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [TW-1:0] tag,
                         input logic [PW-1:0] ppn, input logic [AW-1:0] idx);
      repeat (2) @(negedge clk);
      wait_ready();
      cmd_valid = 1'b1; cmd_op = op; cmd_tag = tag; cmd_ppn = ppn; cmd_index = idx;
      model_apply(op, tag, ppn, idx);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_tag   = TW'($urandom);
      cmd_ppn   = PW'($urandom);
      cmd_index = AW'($urandom);
   endtask

   task automatic lookup(input logic [TW-1:0] tag);
      lexp_t e;
      lookup_tag = tag;
      e.due = cyc + 2; e.hit = 1'b0; e.ppn = '0;
      for (int i = 0; i < N; i++) begin
         if (m_val[i] && m_tag[i] == tag) begin
            e.hit = 1'b1; e.ppn = m_ppn[i];
         end
      end
      lk_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: lookup results by due cycle, CAM strobes against the expected-operation queue.
   lexp_t le;
   wexp_t we_e;
   always @(negedge clk) begin
      if (lk_q.size() > 0 && lk_q[0].due <= cyc) begin
         le = lk_q.pop_front();
         check("lookup_hit", 32'(lookup_hit), 32'(le.hit));
         check("lookup_ppn", 32'(lookup_ppn), 32'(le.ppn));
         $display("lookup tag=%h hit=%b ppn=%h", lookup_tag, lookup_hit, lookup_ppn);
      end
      if (cam_write_enable || cam_write_delete || cam_rst_clr) begin
         check("strobe_while_busy", 32'(cam_write_busy), 32'(0));
         if (wr_q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_strobe: got we=%b del=%b clr=%b, required no strobe",
                     cam_write_enable, cam_write_delete, cam_rst_clr);
         end else begin
            we_e = wr_q.pop_front();
            check("strobe_kind", 32'({cam_write_enable, cam_write_delete, cam_rst_clr}), 32'(we_e.kind));
            if (we_e.kind != K_CLR) check("cam_write_addr", 32'(cam_write_addr), 32'(we_e.addr));
            if (we_e.kind == K_WR) begin
               check("cam_write_data", 32'(cam_write_data), 32'(we_e.data));
               check("stall_in_issue", 32'(lookup_stall), 32'(1));
            end
            $display("cam op kind=%0d addr=%0d data=%h", we_e.kind, cam_write_addr, cam_write_data);
         end
      end
   end

   initial begin
      #600_000;
      $display("FAIL watchdog: run did not complete, required $finish before timeout");
      $fatal(1);
   end

   logic [TW-1:0] pool [40];

   initial begin
      int n;
      int r;
      model_reset();
      for (int i = 0; i < 40; i++) pool[i] = TW'($urandom);

      // Hold an insert through reset and CAM power-up.
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_tag = 16'h1234; cmd_ppn = 16'h00AB;
      model_apply(2'b00, 16'h1234, 16'h00AB, '0);
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
      check("rst_lookup_hit", 32'(lookup_hit), 32'(0));
      check("rst_lookup_ppn", 32'(lookup_ppn), 32'(0));
      check("rst_lookup_stall", 32'(lookup_stall), 32'(0));
      check("rst_strobes", 32'({cam_write_enable, cam_write_delete, cam_rst_clr}), 32'(0));
      check("rst_write_addr", 32'(cam_write_addr), 32'(0));
      check("rst_write_data", 32'(cam_write_data), 32'(0));
      rst = 1'b0;
      n = 0;
      while (!cmd_ready && n < 400) begin
         check("init_ready", 32'(cmd_ready), 32'(!cam_write_busy));
         @(negedge clk);
         n++;
      end
      check("init_timeout", 32'(n >= 400), 32'(0));
      @(negedge clk);
      check("accept_once", 32'(cmd_ready), 32'(0));
      cmd_valid = 1'b0;

      wait_ready();
      lookup(16'h1234);
      lookup(16'h1235);
      do_cmd(2'b00, 16'h1234, 16'h00CD, '0);
      wait_ready();
      lookup(16'h1234);

      // Fill, then evict round-robin.
      do_cmd(2'b10, '0, '0, '0);
      for (int i = 0; i < N; i++) do_cmd(2'b00, TW'(16'h2000 + i), PW'(16'h0100 + i), '0);
      for (int i = 0; i < 3; i++) do_cmd(2'b00, TW'(16'h3000 + i), PW'(16'h0300 + i), '0);
      wait_ready();
      for (int i = 0; i < 4; i++) lookup(TW'(16'h2000 + i));
      for (int i = 0; i < 3; i++) lookup(TW'(16'h3000 + i));

      do_cmd(2'b01, '0, '0, 5'd5);
      wait_ready();
      lookup(16'h2005);
      lookup(16'h2006);
      do_cmd(2'b00, 16'h4000, 16'h0440, '0);
      wait_ready();
      lookup(16'h4000);

      // Flush with ten valid entries.
      do_cmd(2'b10, '0, '0, '0);
      for (int i = 0; i < 10; i++) do_cmd(2'b00, TW'(16'h6000 + i), PW'(16'h0600 + i), '0);
      do_cmd(2'b10, '0, '0, '0);
      @(negedge clk);
      check("flush_ready_low", 32'(cmd_ready), 32'(0));
      wait_ready();
      for (int i = 0; i < 10; i++) lookup(TW'(16'h6000 + i));

      // Reset while waiting on the CAM.
      repeat (2) @(negedge clk);
      wait_ready();
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_tag = 16'h7777; cmd_ppn = 16'h0777;
      model_apply(2'b00, 16'h7777, 16'h0777, '0);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!cam_write_enable && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_test_strobe_seen", 32'(n >= 20), 32'(0));
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_wait_stall", 32'(lookup_stall), 32'(0));
      check("rst_wait_ready", 32'(cmd_ready), 32'(0));
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("post_rst_quiet", 32'({cam_write_enable, cam_write_delete, cam_rst_clr}), 32'(0));
         @(negedge clk);
      end
      model_reset();
      do_cmd(2'b10, '0, '0, '0);

      // Randomised traffic with a tag pool larger than the TLB.
      for (int it = 0; it < 220; it++) begin
         r = $urandom_range(0, 99);
         if (r < 38) do_cmd(2'b00, pool[$urandom_range(0, 39)], PW'($urandom), '0);
         else if (r < 48) do_cmd(2'b01, '0, '0, AW'($urandom_range(0, N - 1)));
         else if (r < 51) do_cmd(2'b11, TW'($urandom), PW'($urandom), AW'($urandom));
         else if (r < 53) do_cmd(2'b10, '0, '0, '0);
         else begin
            wait_ready();
            repeat ($urandom_range(1, 4)) lookup(pool[$urandom_range(0, 39)]);
         end
      end
      wait_ready();
      for (int i = 0; i < 40; i++) lookup(pool[i]);

      repeat (8) @(negedge clk);
      check("queues_drained", 32'(lk_q.size() + wr_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
